// File: rtl/mem_bus_arbiter_pkg.sv
// Shared widths, counter size and FSM encoding for the memory bus arbiter.
// Extends the global address/data line parameters used across the core.
package mem_bus_arbiter_pkg;

   localparam int adlines      = 8;
   localparam int datalines    = 32;
   localparam int arbstatesize = 2;
   localparam int cntsize      = 4;

   typedef enum logic [arbstatesize-1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } arb_state_e;

   // Strobe counter preload: the strobe is held lat cycles, counting down to 0.
   function automatic logic [cntsize-1:0] lat_preload(input int lat);
      return cntsize'(lat - 1);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Two-input round-robin picker with optional lock hold-off.
// Purely combinational so it can be replicated for wider arbiters.
module arb_rr_pick (
   input  logic req0,
   input  logic req1,
   input  logic last_gnt,
   input  logic lock_vld,
   input  logic lock_port,
   input  logic lock_hold,
   output logic grant_valid,
   output logic winner
);

   logic pref;

   // A released lock hands the tie to the port that was held off.
   assign pref = lock_vld ? ~lock_port : ~last_gnt;

   // Choose the winner: an active lock wins, otherwise round-robin on ties.
   always_comb begin
      grant_valid = 1'b0;
      winner      = 1'b0;
      if (lock_vld && lock_hold) begin
         grant_valid = 1'b1;
         winner      = lock_port;
      end else if (req0 && req1) begin
         grant_valid = 1'b1;
         winner      = pref;
      end else if (req0) begin
         grant_valid = 1'b1;
         winner      = 1'b0;
      end else if (req1) begin
         grant_valid = 1'b1;
         winner      = 1'b1;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory bus between two ports.
// Optional bus locking for read-modify-write is enabled by MEM_ARB_LOCK_EN.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int adlines   = mem_bus_arbiter_pkg::adlines,
   parameter int datalines = mem_bus_arbiter_pkg::datalines,
   parameter int MEM_LAT   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0,
   input  logic                 req1,
   input  logic                 wr0,
   input  logic                 wr1,
   input  logic [adlines-1:0]   addr0,
   input  logic [adlines-1:0]   addr1,
   input  logic [datalines-1:0] wdata0,
   input  logic [datalines-1:0] wdata1,
`ifdef MEM_ARB_LOCK_EN
   input  logic                 lock0,
   input  logic                 lock1,
`endif
   output logic                 ack0,
   output logic                 ack1,
   output logic [datalines-1:0] rdata,
   output logic [adlines-1:0]   mem_addr,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [datalines-1:0] mem_wdata,
   input  logic [datalines-1:0] mem_rdata,
   output logic                 busy,
   output logic                 owner
);

   localparam logic [cntsize-1:0] CNT_INIT = lat_preload(MEM_LAT);

   arb_state_e           state_q, state_d;
   logic [cntsize-1:0]   cnt_q, cnt_d;
   logic                 last_gnt_q, last_gnt_d;
   logic                 owner_q, owner_d;
   logic                 ack0_q, ack0_d;
   logic                 ack1_q, ack1_d;
   logic [adlines-1:0]   mem_addr_q, mem_addr_d;
   logic                 mem_read_q, mem_read_d;
   logic                 mem_write_q, mem_write_d;
   logic [datalines-1:0] mem_wdata_q, mem_wdata_d;
   logic [datalines-1:0] rdata_q, rdata_d;

   logic                 grant_valid;
   logic                 winner;
   logic                 sel_wr;
   logic                 lock_vld;
   logic                 lock_port;
   logic                 lock_hold;

`ifdef MEM_ARB_LOCK_EN
   logic lock_q, lock_d;
   logic lock_port_q, lock_port_d;
   logic own_lock;

   assign lock_vld  = lock_q;
   assign lock_port = lock_port_q;
   assign lock_hold = lock_port_q ? (req1 & lock1) : (req0 & lock0);
   assign own_lock  = owner_q ? lock1 : lock0;
`else
   assign lock_vld  = 1'b0;
   assign lock_port = 1'b0;
   assign lock_hold = 1'b0;
`endif

   arb_rr_pick u_pick (
      .req0        (req0),
      .req1        (req1),
      .last_gnt    (last_gnt_q),
      .lock_vld    (lock_vld),
      .lock_port   (lock_port),
      .lock_hold   (lock_hold),
      .grant_valid (grant_valid),
      .winner      (winner)
   );

   assign sel_wr = winner ? wr1 : wr0;

   // State and datapath registers; reset drops strobes and acks at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         cnt_q       <= '0;
         last_gnt_q  <= 1'b1;
         owner_q     <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_gnt_q  <= last_gnt_d;
         owner_q     <= owner_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         mem_addr_q  <= mem_addr_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

`ifdef MEM_ARB_LOCK_EN
   // Lock holder registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q      <= 1'b0;
         lock_port_q <= 1'b0;
      end else begin
         lock_q      <= lock_d;
         lock_port_q <= lock_port_d;
      end
   end
`endif

   // Next-state: grant, hold strobe for MEM_LAT cycles, then one ack cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (grant_valid) state_d = ARB_ACCESS;
         end
         ARB_ACCESS: begin
            if (cnt_q == '0) state_d = ARB_RESP;
         end
         ARB_RESP: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Datapath next values: latch the winner, capture read data, pulse ack.
   always_comb begin
      cnt_d       = cnt_q;
      last_gnt_d  = last_gnt_q;
      owner_d     = owner_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
`ifdef MEM_ARB_LOCK_EN
      lock_d      = lock_q;
      lock_port_d = lock_port_q;
`endif
      unique case (state_q)
         ARB_IDLE: begin
            if (grant_valid) begin
               owner_d     = winner;
               mem_addr_d  = winner ? addr1 : addr0;
               mem_wdata_d = winner ? wdata1 : wdata0;
               mem_write_d = sel_wr;
               mem_read_d  = ~sel_wr;
               cnt_d       = CNT_INIT;
            end
         end
         ARB_ACCESS: begin
            if (cnt_q == '0) begin
               if (mem_read_q) rdata_d = mem_rdata;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               ack0_d      = ~owner_q;
               ack1_d      = owner_q;
               last_gnt_d  = owner_q;
            end else begin
               cnt_d = cnt_q - cntsize'(1);
            end
         end
         ARB_RESP: begin
         end
         default: begin
         end
      endcase
`ifdef MEM_ARB_LOCK_EN
      // Holder let go: drop the lock and make it the last grantee.
      if ((state_q == ARB_IDLE) && lock_q && !lock_hold) begin
         lock_d     = 1'b0;
         last_gnt_d = lock_port_q;
      end
      // Completion with lock high keeps the bus and freezes round-robin.
      if ((state_q == ARB_ACCESS) && (cnt_q == '0)) begin
         lock_d      = own_lock;
         lock_port_d = owner_q;
         if (own_lock) last_gnt_d = last_gnt_q;
      end
`endif
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_wdata = mem_wdata_q;
   assign owner     = owner_q;
   assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter (instances with MEM_LAT 1 and 3).
// Lock scenario is built only when MEM_ARB_LOCK_EN is defined.
module tb_mem_bus_arbiter;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam logic [DW-1:0] D5 = 32'hDEAD_BEEF;
   localparam logic [DW-1:0] D7 = 32'hCAFE_F00D;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0 [2];
   logic          req1 [2];
   logic          wr0 [2];
   logic          wr1 [2];
   logic [AW-1:0] addr0 [2];
   logic [AW-1:0] addr1 [2];
   logic [DW-1:0] wdata0 [2];
   logic [DW-1:0] wdata1 [2];
   logic          ack0 [2];
   logic          ack1 [2];
   logic [DW-1:0] rdata [2];
   logic [AW-1:0] mem_addr [2];
   logic          mem_read [2];
   logic          mem_write [2];
   logic [DW-1:0] mem_wdata [2];
   logic [DW-1:0] mem_rdata [2];
   logic          busy [2];
   logic          owner [2];
`ifdef MEM_ARB_LOCK_EN
   logic          lock0 [2];
   logic          lock1 [2];
`endif

   logic [DW-1:0] mem [256];

   typedef struct packed {
      logic          port;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t sb_d0[$];
   exp_t sb_d1[$];
   int   passed = 0;
   int   failed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   assign mem_rdata[0] = mem[mem_addr[0]];
   assign mem_rdata[1] = mem[mem_addr[1]];

   mem_bus_arbiter #(.MEM_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .req0(req0[0]), .req1(req1[0]),
      .wr0(wr0[0]), .wr1(wr1[0]),
      .addr0(addr0[0]), .addr1(addr1[0]),
      .wdata0(wdata0[0]), .wdata1(wdata1[0]),
`ifdef MEM_ARB_LOCK_EN
      .lock0(lock0[0]), .lock1(lock1[0]),
`endif
      .ack0(ack0[0]), .ack1(ack1[0]),
      .rdata(rdata[0]), .mem_addr(mem_addr[0]),
      .mem_read(mem_read[0]), .mem_write(mem_write[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
      .busy(busy[0]), .owner(owner[0])
   );

   mem_bus_arbiter #(.MEM_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .req0(req0[1]), .req1(req1[1]),
      .wr0(wr0[1]), .wr1(wr1[1]),
      .addr0(addr0[1]), .addr1(addr1[1]),
      .wdata0(wdata0[1]), .wdata1(wdata1[1]),
`ifdef MEM_ARB_LOCK_EN
      .lock0(lock0[1]), .lock1(lock1[1]),
`endif
      .ack0(ack0[1]), .ack1(ack1[1]),
      .rdata(rdata[1]), .mem_addr(mem_addr[1]),
      .mem_read(mem_read[1]), .mem_write(mem_write[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
      .busy(busy[1]), .owner(owner[1])
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int d, input logic p, input logic [DW-1:0] r);
      exp_t e;
      e.port  = p;
      e.rdata = r;
      if (d == 0) sb_d0.push_back(e);
      else sb_d1.push_back(e);
   endtask

   function automatic int sb_size(input int d);
      return (d == 0) ? sb_d0.size() : sb_d1.size();
   endfunction

   task automatic sb_pop(input int d, output exp_t e);
      if (d == 0) e = sb_d0.pop_front();
      else e = sb_d1.pop_front();
   endtask

   task automatic set_req(input int d, input logic p, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd);
      if (p) begin
         req1[d] = 1'b1; wr1[d] = w; addr1[d] = a; wdata1[d] = wd;
      end else begin
         req0[d] = 1'b1; wr0[d] = w; addr0[d] = a; wdata0[d] = wd;
      end
   endtask

   task automatic wait_ack(input int d, input int maxc, output int n);
      n = 0;
      for (int i = 1; i <= maxc; i++) begin
         @(negedge clk);
         if (ack0[d] || ack1[d]) begin
            n = i;
            break;
         end
      end
      if (n == 0) chk($sformatf("ack_timeout_d%0d", d), 64'd1, 64'd0);
   endtask

   task automatic access(input int d, input logic p, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] r);
      int n;
      @(posedge clk); #1;
      set_req(d, p, w, a, wd);
      push(d, p, r);
      wait_ack(d, 40, n);
      @(posedge clk); #1;
      req0[d] = 1'b0;
      req1[d] = 1'b0;
   endtask

   task automatic pulse_rst();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Scoreboard monitors: every ack pops one expected grant.
   for (genvar k = 0; k < 2; k++) begin : g_mon
      always @(negedge clk) begin
         exp_t e;
         if (!rst) begin
            chk($sformatf("rw_excl_d%0d", k),
                64'(mem_read[k] & mem_write[k]), 64'd0);
            if (ack0[k] || ack1[k]) begin
               chk("ack_onehot", 64'(ack0[k] & ack1[k]), 64'd0);
               if (sb_size(k) == 0) begin
                  chk($sformatf("unexpected_ack_d%0d", k), 64'd1, 64'd0);
               end else begin
                  sb_pop(k, e);
                  chk($sformatf("sb_port_d%0d", k), 64'(ack1[k]), 64'(e.port));
                  chk($sformatf("sb_rdata_d%0d", k), 64'(rdata[k]), 64'(e.rdata));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int cnt;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[5] = D5;
      mem[7] = D7;
      for (int d = 0; d < 2; d++) begin
         req0[d] = 0; req1[d] = 0; wr0[d] = 0; wr1[d] = 0;
         addr0[d] = '0; addr1[d] = '0; wdata0[d] = '0; wdata1[d] = '0;
`ifdef MEM_ARB_LOCK_EN
         lock0[d] = 0; lock1[d] = 0;
`endif
      end
      rst = 1'b1;
      #2;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_ctl_d%0d", d),
             64'({ack0[d], ack1[d], mem_read[d], mem_write[d], busy[d], owner[d]}),
             64'd0);
         chk($sformatf("rst_data_d%0d", d),
             64'(rdata[d] | mem_wdata[d] | DW'(mem_addr[d])), 64'd0);
      end
      #10;
      rst = 1'b0;

      // Single read, MEM_LAT=1
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, 8'd5, '0);
      push(0, 1'b0, D5);
      @(negedge clk);
      chk("rd_idle_busy", 64'(busy[0]), 64'd0);
      @(negedge clk);
      chk("rd_strobe", 64'({mem_read[0], mem_write[0]}), 64'b10);
      chk("rd_addr", 64'(mem_addr[0]), 64'd5);
      chk("rd_busy_owner", 64'({busy[0], owner[0], ack0[0]}), 64'b100);
      @(negedge clk);
      chk("rd_ack", 64'({ack0[0], ack1[0]}), 64'b10);
      chk("rd_strobe_off", 64'({mem_read[0], mem_write[0]}), 64'd0);
      chk("rd_data", 64'(rdata[0]), 64'(D5));
      @(posedge clk); #1;
      req0[0] = 1'b0;
      @(negedge clk);
      chk("rd_done", 64'({ack0[0], busy[0]}), 64'd0);

      // Write, MEM_LAT=3, after a read that sets rdata
      access(1, 1'b0, 1'b0, 8'd7, '0, D7);
      @(posedge clk); #1;
      set_req(1, 1'b1, 1'b1, 8'h10, 32'h1234);
      push(1, 1'b1, D7);
      cnt = 0;
      n = 0;
      for (int i = 0; i < 12 && n == 0; i++) begin
         @(negedge clk);
         if (mem_write[1]) begin
            cnt++;
            chk("wr_addr", 64'(mem_addr[1]), 64'h10);
            chk("wr_data", 64'(mem_wdata[1]), 64'h1234);
         end
         if (ack1[1]) n = i;
      end
      chk("wr_strobe_cycles", 64'(cnt), 64'd3);
      chk("wr_ack_latency", 64'(n), 64'd4);
      chk("wr_rdata_kept", 64'(rdata[1]), 64'(D7));
      @(posedge clk); #1;
      req1[1] = 1'b0;

      // Contention after reset: 0,1,0,1,0,1 spaced MEM_LAT+2
      pulse_rst();
      set_req(1, 1'b0, 1'b0, 8'd5, '0);
      set_req(1, 1'b1, 1'b0, 8'd7, '0);
      for (int i = 0; i < 3; i++) begin
         push(1, 1'b0, D5);
         push(1, 1'b1, D7);
      end
      for (int i = 0; i < 6; i++) begin
         wait_ack(1, 20, n);
         chk($sformatf("rr_grant%0d", i), 64'(ack1[1]), 64'(i % 2));
         chk($sformatf("rr_spacing%0d", i), 64'(n), 64'd5);
      end
      @(posedge clk); #1;
      req0[1] = 1'b0;
      req1[1] = 1'b0;

      // req dropped during ACCESS
      @(posedge clk); #1;
      set_req(1, 1'b0, 1'b0, 8'd5, '0);
      push(1, 1'b0, D5);
      @(negedge clk);
      @(negedge clk);
      chk("drop_in_access", 64'({busy[1], mem_read[1]}), 64'b11);
      req0[1] = 1'b0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ack0[1]) cnt++;
      end
      chk("drop_ack_once", 64'(cnt), 64'd1);

      // Async reset mid-ACCESS
      @(posedge clk); #1;
      set_req(1, 1'b1, 1'b0, 8'd7, '0);
      @(negedge clk);
      @(negedge clk);
      chk("ar_pre", 64'({busy[1], mem_read[1]}), 64'b11);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_immediate",
          64'({mem_read[1], mem_write[1], busy[1], ack0[1], ack1[1]}), 64'd0);
      req1[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack0[1] || ack1[1]) cnt++;
      end
      chk("ar_no_ack", 64'(cnt), 64'd0);
      access(1, 1'b1, 1'b0, 8'd7, '0, D7);
      chk("ar_after_rdata", 64'(rdata[1]), 64'(D7));

`ifdef MEM_ARB_LOCK_EN
      // Lock held by port 0, then released to port 1
      pulse_rst();
      lock0[1] = 1'b1;
      set_req(1, 1'b0, 1'b0, 8'd5, '0);
      set_req(1, 1'b1, 1'b0, 8'd7, '0);
      push(1, 1'b0, D5);
      push(1, 1'b0, D5);
      push(1, 1'b0, D5);
      push(1, 1'b1, D7);
      push(1, 1'b0, D5);
      for (int i = 0; i < 3; i++) begin
         wait_ack(1, 20, n);
         chk($sformatf("lock_hold%0d", i), 64'(ack0[1]), 64'd1);
      end
      lock0[1] = 1'b0;
      wait_ack(1, 20, n);
      chk("lock_release_p1", 64'(ack1[1]), 64'd1);
      wait_ack(1, 20, n);
      chk("lock_after_p0", 64'(ack0[1]), 64'd1);
      @(posedge clk); #1;
      req0[1] = 1'b0;
      req1[1] = 1'b0;
`endif

      repeat (4) @(negedge clk);
      chk("sb_empty_d0", 64'(sb_d0.size()), 64'd0);
      chk("sb_empty_d1", 64'(sb_d1.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory address/data bus between two requesters.
- Port 0 is the CPU control unit (fetch/load/store); port 1 is the program loader/DMA.
- Fair round-robin arbitration, one outstanding transaction at a time, fixed-latency memory timing, one-cycle ack per completed access.
- Sits between the requesters and the memory; the top level maps mem_wdata/mem_write onto the tri-state databus.

Parameters:
- adlines, 8: address width (matches parameters.v).
- datalines, 32: data width.
- MEM_LAT, 1: cycles the strobe is held per access; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0, req1  in  1  access request, held until ack.
- wr0, wr1  in  1  1 = write, 0 = read; valid while req is high.
- addr0, addr1  in  adlines  request address.
- wdata0, wdata1  in  datalines  write data.
- ack0, ack1  out  1  one-cycle completion pulse.
- rdata  out  datalines  read data, shared; valid with ack and held afterwards.
- mem_addr  out  adlines  memory address.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_wdata  out  datalines  write data to memory.
- mem_rdata  in  datalines  data from memory.
- busy  out  1  high in ACCESS and RESP.
- owner  out  1  granted port; meaningful only while busy.

Behaviour:
- Reset (async, immediate): all outputs 0; state = IDLE; cnt = 0; last_gnt = 1, so port 0 wins the first tie.
- State machine: IDLE, ACCESS, RESP. Encoding comes from the package; all registers update on posedge clk.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that port.
  - Both req: grant !last_gnt.
  - On grant: latch the winner's addr/wr/wdata into mem_addr/mem_write/mem_wdata; set mem_read = !wr; owner = winner; cnt = MEM_LAT-1; go to ACCESS.
- ACCESS:
  - Strobes, address and data are held stable.
  - If cnt == 0: rdata <= mem_rdata (read only; a write leaves rdata unchanged); clear strobes; ack[owner] <= 1; last_gnt <= owner; go to RESP.
  - Otherwise cnt decrements.
- RESP: ack high for exactly this cycle; clear ack; go to IDLE.
- Latency: req sampled at edge E0; ack visible after edge E0+MEM_LAT; RESP lasts one cycle.
- Back-to-back throughput: one access per MEM_LAT+2 cycles.
- Requester rule: deassert req on the edge after ack is seen. A req still high in IDLE is treated as a new request.
- Boundary cases:
  - req dropped mid-ACCESS: ignored; the access completes and ack still pulses.
  - The loser's req stays pending, with no starvation. With both requesting continuously, grants alternate 0,1,0,1.
  - A new req arriving in ACCESS/RESP waits for IDLE.
  - rst mid-access: strobes drop immediately, no ack is issued, and the requester must re-request.
  - mem_read and mem_write are never both 1.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- When defined:
  - Adds inputs lock0 and lock1 (1 bit each).
  - If the owner's lock is high in the cycle ACCESS completes, the next IDLE grants only that port. The other port waits even if it is requesting, and last_gnt is not updated.
  - The lock is released when the owner reaches IDLE with its lock low, or with its req low.
  - Used for load-modify-store sequences.
- When undefined: no lock ports; pure round-robin as described above.

Decomposition:
- Shared package (extends parameters.v): state encodings ARB_IDLE=0, ARB_ACCESS=1, ARB_RESP=2; arbstatesize=2; adlines; datalines.
- One natural sub-module: arb_rr_pick, a two-input round-robin picker (req0, req1, last_gnt, optional lock state) producing grant_valid and winner. Combinational, reused for later extension beyond two ports.

Test Plan:
- Single read: MEM_LAT=1, memory[5]=32'hDEAD_BEEF, req0 with wr0=0, addr0=5. Expect mem_read=1 and mem_addr=5 for one cycle; ack0 one cycle later; rdata=32'hDEAD_BEEF.
- Write: MEM_LAT=3, req1 with wr1=1, addr1=8'h10, wdata1=32'h1234. Expect mem_write=1 for exactly 3 cycles with stable address and data; ack1 after 3 cycles; rdata unchanged.
- Contention: req0 and req1 both held continuously for 6 accesses after reset. Expect grant order 0,1,0,1,0,1 and acks spaced MEM_LAT+2 cycles apart.
- Drop mid-access: req0 deasserted during ACCESS. Expect the access to complete and ack0 to still pulse once.
- Async reset: rst asserted mid-ACCESS between clock edges. Expect mem_read/mem_write/busy=0 immediately; no ack; a subsequent req1 is served normally.
- MEM_ARB_LOCK_EN: lock0=1 with both ports requesting. Expect port 0 granted repeatedly until lock0=0, then port 1 granted next.
